pipe_ctrl: RTL

Pipeline sequencing controller for the five-stage core (F, D, A, M, W). It sits beside the decoder and keeps a shadow copy of the destination and type of every in-flight instruction. From that copy it generates the stage enables, inserts load-use bubbles, freezes the pipe while data memory is not ready, selects forwarding sources for the ALU operands and gates register-file commit. It holds no datapath values, only control.

---
 rtl/pipe_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- sequencing controller for the five-stage core (F, D, A, M, W).
//
// This block keeps a shadow copy of the destination and type of every
// instruction in A, M and W. It holds control state only, with no datapath
// values. From that shadow copy it derives the following:
//   * stage enables, with a one-cycle bubble for load-use hazards,
//   * a full freeze while a memory op in M waits for data memory,
//   * registered forwarding selects for the instruction entering A,
//   * the register-file write strobe and index,
//   * a sticky timeout flag when memory stays unready too long.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   D_valid               D holds a real instruction
//   D_addr_r1/_r2         source registers of the D instruction
//   D_use_r2              D instruction reads r2
//   D_addr_rd, D_We       destination of the D instruction and its write flag
//   D_is_load, D_is_mem   D instruction is a load / any memory op
//   MEM_ready             data memory completes its access this cycle
//   F_en..W_en            stage register enables
//   A_bubble              load an invalid instruction into A this cycle
//   A_fwd1, A_fwd2        operand source for A: 00 regfile, 01 M, 10 W
//   W_commit, W_addr      register-file write strobe and index
//   MEM_err               sticky memory-timeout flag
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int TIMEOUT          = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        D_valid,
  input  logic [REG_ADDRESS_SIZE-1:0] D_addr_r1,
  input  logic [REG_ADDRESS_SIZE-1:0] D_addr_r2,
  input  logic                        D_use_r2,
  input  logic [REG_ADDRESS_SIZE-1:0] D_addr_rd,
  input  logic                        D_We,
  input  logic                        D_is_load,
  input  logic                        D_is_mem,
  input  logic                        MEM_ready,
  output logic                        F_en,
  output logic                        D_en,
  output logic                        A_en,
  output logic                        M_en,
  output logic                        W_en,
  output logic                        A_bubble,
  output logic [1:0]                  A_fwd1,
  output logic [1:0]                  A_fwd2,
  output logic                        W_commit,
  output logic [REG_ADDRESS_SIZE-1:0] W_addr,
  output logic                        MEM_err
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef struct packed {
    logic                        valid;
    logic [REG_ADDRESS_SIZE-1:0] rd;
    logic                        we;
    logic                        is_load;
    logic                        is_mem;
  } slot_t;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  localparam slot_t SLOT_EMPTY = '0;

  slot_t      sa_q, sm_q, sw_q;
  slot_t      sa_d, sm_d, sw_d;
  logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic       err_q;
  logic       freeze, luse;

  // The load flag is never needed past M, and the mem flag is never needed
  // in W. Those bits travel with the slot only to keep the slots uniform.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{sm_q.is_load, sw_q.is_load, sw_q.is_mem};

  // A slot produces a register value only if it writes a register other than x0.
  function automatic logic produces(input slot_t s);
    return s.valid & s.we & (s.rd != '0);
  endfunction

  // The newest producer wins. The instruction now in A will be in M when
  // the consumer reaches A.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDRESS_SIZE-1:0] src,
                                         input slot_t a, input slot_t m);
    if (produces(a) && (src == a.rd)) return 2'b01;
    if (produces(m) && (src == m.rd)) return 2'b10;
    return 2'b00;
  endfunction

  assign freeze = sm_q.valid & sm_q.is_mem & ~MEM_ready;
  assign luse   = ~freeze & D_valid & sa_q.is_load & produces(sa_q) &
                  ((D_addr_r1 == sa_q.rd) | (D_use_r2 & (D_addr_r2 == sa_q.rd)));

  // NOTE: every signal in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    sa_d     = sa_q;
    sm_d     = sm_q;
    sw_d     = sw_q;
    fwd1_d   = fwd1_q;
    fwd2_d   = fwd2_q;
    F_en     = 1'b1;
    D_en     = 1'b1;
    A_en     = 1'b1;
    M_en     = 1'b1;
    W_en     = 1'b1;
    A_bubble = 1'b0;

    if (freeze) begin
      F_en = 1'b0;
      D_en = 1'b0;
      A_en = 1'b0;
      M_en = 1'b0;
      W_en = 1'b0;
    end else if (luse) begin
      F_en     = 1'b0;
      D_en     = 1'b0;
      A_bubble = 1'b1;
      sa_d     = SLOT_EMPTY;
      sm_d     = sa_q;
      sw_d     = sm_q;
      fwd1_d   = 2'b00;
      fwd2_d   = 2'b00;
    end else begin
      sa_d   = '{valid: D_valid, rd: D_addr_rd, we: D_We,
                 is_load: D_is_load, is_mem: D_is_mem};
      sm_d   = sa_q;
      sw_d   = sm_q;
      fwd1_d = D_valid ? fwd_sel(D_addr_r1, sa_q, sm_q) : 2'b00;
      fwd2_d = (D_valid & D_use_r2) ? fwd_sel(D_addr_r2, sa_q, sm_q) : 2'b00;
    end
  end

  assign W_commit = produces(sw_q) & ~freeze;
  assign W_addr   = sw_q.rd;
  assign A_fwd1   = fwd1_q;
  assign A_fwd2   = fwd2_q;
  assign MEM_err  = err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sa_q    <= SLOT_EMPTY;
      sm_q    <= SLOT_EMPTY;
      sw_q    <= SLOT_EMPTY;
      fwd1_q  <= 2'b00;
      fwd2_q  <= 2'b00;
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      sm_q   <= sm_d;
      sw_q   <= sw_d;
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
      case (state_q)
        ST_RUN: begin
          if (freeze) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
          end
        end
        ST_WAIT: begin
          if (MEM_ready) begin
            state_q <= ST_RUN;
          end else if (cnt_q != TMAX) begin
            // The counter saturates. The flag stays set and the pipe keeps waiting.
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q + 1'b1 == TMAX) err_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule
